// File: rtl/priority_enc_rr_v.sv
// priority_enc_rr_v: registered fixed/round-robin priority encoder that holds each grant until acknowledged
module priority_enc_rr_v #(
  parameter int WIDTH = 8,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_code,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_ack,
  output logic [OUT_W-1:0] o_code,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_valid,
  output logic             o_multi
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [OUT_W-1:0] ptr, ptr_d, fix_code, rr_code, code_d;
  logic [WIDTH-1:0] onehot_d;
  logic [OUT_W:0] idx;
  logic rr_held, rr_held_d, multi_d, load, found;
  assign load = i_en & (|i_code) & ((state == IDLE) | i_ack);
  assign ptr_d = (state == GRANT && i_ack && rr_held)
               ? ((o_code == OUT_W'(WIDTH - 1)) ? '0 : o_code + 1'b1) : ptr;
  assign o_valid = (state == GRANT);
  // Candidate grants: highest set bit, and first set bit at or above the (already updated) pointer with wrap
  always_comb begin
    fix_code = '0;
    rr_code = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < WIDTH; k++) if (i_code[k]) fix_code = OUT_W'(k);
    for (int k = 0; k < WIDTH; k++) begin
      idx = {1'b0, ptr_d} + (OUT_W + 1)'(k);
      idx = (idx >= (OUT_W + 1)'(WIDTH)) ? idx - (OUT_W + 1)'(WIDTH) : idx;
      if (!found && i_code[idx[OUT_W-1:0]]) begin
        found = 1'b1;
        rr_code = idx[OUT_W-1:0];
      end
    end
  end
  // Next state and next registered outputs: load a new grant, drop to idle on a bare ack, otherwise hold
  always_comb begin
    state_d = state;
    code_d = o_code;
    onehot_d = o_onehot;
    multi_d = o_multi;
    rr_held_d = rr_held;
    if (load) begin
      state_d = GRANT;
      code_d = i_mode ? rr_code : fix_code;
      onehot_d = WIDTH'(1) << code_d;
      multi_d = |(i_code & (i_code - 1'b1));
      rr_held_d = i_mode;
    end else if (state == GRANT && i_ack) begin
      state_d = IDLE;
      code_d = '0;
      onehot_d = '0;
      multi_d = 1'b0;
      rr_held_d = 1'b0;
    end
  end
  // State, pointer and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= '0;
      o_code <= '0;
      o_onehot <= '0;
      o_multi <= 1'b0;
      rr_held <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      o_code <= code_d;
      o_onehot <= onehot_d;
      o_multi <= multi_d;
      rr_held <= rr_held_d;
    end
  end
endmodule

// File: tb/tb_priority_enc_rr_v.sv
// tb_priority_enc_rr_v: directed and random checks of priority_enc_rr_v against a behavioural model
module tb_priority_enc_rr_v;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n, en, mode, ack;
  logic [W-1:0] code;
  logic [2:0] o_code;
  logic [W-1:0] o_onehot;
  logic o_valid, o_multi;
  int n_checks = 0;
  int n_fail = 0;
  int m_valid = 0, m_code = 0, m_multi = 0, m_ptr = 0, m_rr = 0;

  priority_enc_rr_v #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_code(code), .i_en(en), .i_mode(mode), .i_ack(ack),
    .o_code(o_code), .o_onehot(o_onehot), .o_valid(o_valid), .o_multi(o_multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int highest(input logic [W-1:0] c);
    int r = 0;
    for (int i = 0; i < W; i++) if (c[i]) r = i;
    return r;
  endfunction

  function automatic int rr_pick(input logic [W-1:0] c, input int p);
    for (int off = 0; off < W; off++) if (c[(p + off) % W]) return (p + off) % W;
    return 0;
  endfunction

  function automatic int ones(input logic [W-1:0] c);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(c[i]);
    return n;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_valid = 0; m_code = 0; m_multi = 0; m_ptr = 0; m_rr = 0;
    end else begin
      if (m_valid == 1 && ack && m_rr == 1) m_ptr = (m_code + 1) % W;
      if (en && code != 0 && (m_valid == 0 || ack)) begin
        m_valid = 1;
        m_code = mode ? rr_pick(code, m_ptr) : highest(code);
        m_multi = (ones(code) > 1) ? 1 : 0;
        m_rr = mode ? 1 : 0;
      end else if (m_valid == 1 && ack) begin
        m_valid = 0; m_code = 0; m_multi = 0; m_rr = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic m, input logic a, input logic [W-1:0] c);
    rst_n = r; en = e; mode = m; ack = a; code = c;
    @(posedge clk);
    model_update();
    #1;
    check("code", 32'(o_code), 32'(m_code));
    check("onehot", 32'(o_onehot), m_valid == 1 ? 32'(1) << m_code : 32'd0);
    check("valid", 32'(o_valid), 32'(m_valid));
    check("multi", 32'(o_multi), 32'(m_multi));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; ack = 1'b0; code = '0;
    step(0, 1, 0, 0, 8'hFF);
    step(0, 1, 0, 0, 8'hFF);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_onehot", 32'(o_onehot), 0);
    step(1, 1, 1, 0, 8'hFF);
    check("rst_ptr0", 32'(o_code), 0);
    step(1, 0, 1, 1, 8'h00);
    step(1, 1, 0, 0, 8'b0010_0110);
    check("fix_code", 32'(o_code), 5);
    check("fix_onehot", 32'(o_onehot), 32'h20);
    check("fix_multi", 32'(o_multi), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 8'h01);
      check("hold_code", 32'(o_code), 5);
    end
    step(1, 0, 0, 1, 8'h00);
    check("ack_idle", 32'(o_valid), 0);
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 1, 8'hFF);
      check("sweep_code", 32'(o_code), 32'(i % W));
      check("sweep_valid", 32'(o_valid), 1);
    end
    step(1, 1, 1, 1, 8'h20);
    check("rr_five", 32'(o_code), 5);
    step(1, 1, 1, 1, 8'b0000_0101);
    check("rr_wrap", 32'(o_code), 0);
    step(1, 1, 1, 1, 8'b0000_0101);
    check("rr_skip", 32'(o_code), 2);
    step(1, 0, 1, 1, 8'h00);
    step(1, 1, 1, 0, 8'h10);
    check("single_code", 32'(o_code), 4);
    check("single_multi", 32'(o_multi), 0);
    step(1, 0, 1, 1, 8'h00);
    step(1, 1, 1, 0, 8'h00);
    check("empty_valid", 32'(o_valid), 0);
    step(1, 1, 1, 0, 8'hFF);
    check("ptr_kept", 32'(o_code), 5);
    step(1, 0, 1, 1, 8'h00);
    step(1, 1, 0, 0, 8'hFF);
    check("freeze_load", 32'(o_code), 7);
    step(1, 1, 1, 0, 8'hFF);
    check("freeze_hold", 32'(o_code), 7);
    step(1, 0, 1, 1, 8'h00);
    step(1, 1, 1, 0, 8'hFF);
    check("freeze_ptr", 32'(o_code), 6);
    step(0, 1, 1, 0, 8'hFF);
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_code", 32'(o_code), 0);
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] c;
      int sel;
      sel = int'($urandom_range(0, 3));
      c = (sel == 0) ? '0 : (sel == 1) ? W'(1) << $urandom_range(0, W - 1) : W'($urandom);
      step($urandom_range(0, 60) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
           $urandom_range(0, 2) != 0, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
